// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - main control FSM for the multicycle MIPS datapath
module multicycle_main_control #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Counter only needs to reach MEM_TIMEOUT-1.
    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t          cur;
    state_t          nxt;
    logic [CW-1:0]   wait_cnt;
    logic            wait_state;
    logic            timeout_hit;

    assign state       = cur;
    assign wait_state  = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
    assign timeout_hit = (MEM_TIMEOUT != 0) && wait_state && !mem_ready && (wait_cnt == LIMIT);

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
        nxt         = S_FETCH;
        case (cur)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                nxt     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J:         nxt = S_JUMP;
                    OP_ADDI:      nxt = S_ADDI_EX;
                    default: begin
                        nxt        = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == OP_LW)
                    nxt = S_MEMRD;
                else if (opcode == OP_SW)
                    nxt = S_MEMWR;
                else
                    nxt = S_FETCH;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                nxt     = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                nxt        = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                nxt     = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            default: nxt = S_FETCH;
        endcase
        // mem_ready has priority: timeout_hit already requires !mem_ready.
        if (timeout_hit) begin
            mem_timeout = 1'b1;
            nxt         = S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            cur <= nxt;
            if (wait_state && !mem_ready && !timeout_hit)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - table-driven and sequence checks for multicycle_main_control
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;

    logic       a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_irw, a_m2r, a_rd, a_rw, a_sa;
    logic [1:0] a_sb, a_op, a_ps;
    logic [3:0] a_st;
    logic       a_done, a_ill, a_to;
    logic       b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_m2r, b_rd, b_rw, b_sa;
    logic [1:0] b_sb, b_op, b_ps;
    logic [3:0] b_st;
    logic       b_done, b_ill, b_to;

    // Control bus: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
    //              ALUSrcA,ALUSrcB[2],ALUOp[2],PCSource[2],instr_done,illegal_op,mem_timeout
    logic [18:0] a_ctrl, b_ctrl;
    assign a_ctrl = {a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_irw, a_m2r, a_rd, a_rw, a_sa,
                     a_sb, a_op, a_ps, a_done, a_ill, a_to};
    assign b_ctrl = {b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_m2r, b_rd, b_rw, b_sa,
                     b_sb, b_op, b_ps, b_done, b_ill, b_to};

    multicycle_main_control #(.MEM_TIMEOUT(16)) u16 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .MemRead(a_mr), .MemWrite(a_mw),
        .IRWrite(a_irw), .MemtoReg(a_m2r), .RegDst(a_rd), .RegWrite(a_rw), .ALUSrcA(a_sa),
        .ALUSrcB(a_sb), .ALUOp(a_op), .PCSource(a_ps), .state(a_st),
        .instr_done(a_done), .illegal_op(a_ill), .mem_timeout(a_to));

    multicycle_main_control #(.MEM_TIMEOUT(4)) u4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .MemRead(b_mr), .MemWrite(b_mw),
        .IRWrite(b_irw), .MemtoReg(b_m2r), .RegDst(b_rd), .RegWrite(b_rw), .ALUSrcA(b_sa),
        .ALUSrcB(b_sb), .ALUOp(b_op), .PCSource(b_ps), .state(b_st),
        .instr_done(b_done), .illegal_op(b_ill), .mem_timeout(b_to));

    always #5 clk = ~clk;

    localparam logic [18:0] F_RDY   = 19'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0_0;
    localparam logic [18:0] F_WAIT  = 19'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0_0;
    localparam logic [18:0] F_TO    = 19'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0_1;
    localparam logic [18:0] DEC     = 19'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0_0;
    localparam logic [18:0] DEC_ILL = 19'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1_0;
    localparam logic [18:0] MEMADR  = 19'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0_0;
    localparam logic [18:0] MEMRD   = 19'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0_0;
    localparam logic [18:0] MEMWB   = 19'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0_0;
    localparam logic [18:0] WR_WAIT = 19'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0_0;
    localparam logic [18:0] WR_RDY  = 19'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0_0;
    localparam logic [18:0] EXEC    = 19'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0_0;
    localparam logic [18:0] ALUWB   = 19'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0_0;
    localparam logic [18:0] BRANCH  = 19'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0_0;
    localparam logic [18:0] JUMP    = 19'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0_0;
    localparam logic [18:0] ADDI_WB = 19'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0_0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] ctrl;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mkv(string n, logic [5:0] o, logic r, logic [3:0] s, logic [18:0] c);
        vec_t v;
        v.name = n; v.op = o; v.rdy = r; v.st = s; v.ctrl = c;
        return v;
    endfunction

    // Inputs change at the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic r_n, input logic [5:0] o, input logic r);
        @(negedge clk);
        rst_n = r_n; opcode = o; mem_ready = r;
        #1;
    endtask

    task automatic chk(input string n, input logic [3:0] st_a, input logic [18:0] c_a,
                       input logic [3:0] st_e, input logic [18:0] c_e);
        checks++;
        if (st_a !== st_e || c_a !== c_e) begin
            errors++;
            $display("FAIL %s: state=%0d ctrl=%b, expected state=%0d ctrl=%b", n, st_a, c_a, st_e, c_e);
        end
    endtask

    task automatic step2(input string n, input logic [5:0] o, input logic r,
                         input logic [3:0] st_e, input logic [18:0] c_e);
        drive(1'b1, o, r);
        chk({n, "/t16"}, a_st, a_ctrl, st_e, c_e);
        chk({n, "/t4"}, b_st, b_ctrl, st_e, c_e);
    endtask

    task automatic do_reset();
        drive(1'b0, 6'd0, 1'b0);
        drive(1'b0, 6'd0, 1'b0);
    endtask

    initial begin
        tbl.push_back(mkv("lw_fetch",  RT,   1, 0,  F_RDY));
        tbl.push_back(mkv("lw_dec",    LW,   1, 1,  DEC));
        tbl.push_back(mkv("lw_adr",    LW,   1, 2,  MEMADR));
        tbl.push_back(mkv("lw_rd",     LW,   1, 3,  MEMRD));
        tbl.push_back(mkv("lw_wb",     LW,   1, 4,  MEMWB));
        tbl.push_back(mkv("r_fetch",   RT,   1, 0,  F_RDY));
        tbl.push_back(mkv("r_dec",     RT,   1, 1,  DEC));
        tbl.push_back(mkv("r_exec",    RT,   1, 6,  EXEC));
        tbl.push_back(mkv("r_wb",      RT,   1, 7,  ALUWB));
        tbl.push_back(mkv("beq_fetch", RT,   1, 0,  F_RDY));
        tbl.push_back(mkv("beq_dec",   BEQ,  1, 1,  DEC));
        tbl.push_back(mkv("beq_br",    BEQ,  1, 8,  BRANCH));
        tbl.push_back(mkv("addi_fet",  RT,   1, 0,  F_RDY));
        tbl.push_back(mkv("addi_dec",  ADDI, 1, 1,  DEC));
        tbl.push_back(mkv("addi_ex",   ADDI, 1, 10, MEMADR));
        tbl.push_back(mkv("addi_wb",   ADDI, 1, 11, ADDI_WB));
        tbl.push_back(mkv("ill_fetch", RT,   1, 0,  F_RDY));
        tbl.push_back(mkv("ill_dec",   BAD,  1, 1,  DEC_ILL));
        tbl.push_back(mkv("j_fetch",   BAD,  1, 0,  F_RDY));
        tbl.push_back(mkv("j_dec",     J,    1, 1,  DEC));
        tbl.push_back(mkv("j_jump",    J,    1, 9,  JUMP));
        tbl.push_back(mkv("j_back",    RT,   0, 0,  F_WAIT));

        do_reset();
        drive(1'b1, 6'd0, 1'b0);
        chk("reset/t16", a_st, a_ctrl, 4'd0, F_WAIT);
        chk("reset/t4", b_st, b_ctrl, 4'd0, F_WAIT);

        do_reset();
        foreach (tbl[i]) step2(tbl[i].name, tbl[i].op, tbl[i].rdy, tbl[i].st, tbl[i].ctrl);

        // sw with three wait cycles; on t4 the ready cycle coincides with the timeout count.
        step2("sw_fetch", RT, 1, 0, F_RDY);
        step2("sw_dec",   SW, 1, 1, DEC);
        step2("sw_adr",   SW, 1, 2, MEMADR);
        for (int k = 0; k < 3; k++) step2("sw_wait", SW, 0, 5, WR_WAIT);
        step2("sw_rdy",   SW, 1, 5, WR_RDY);
        step2("sw_back",  RT, 0, 0, F_WAIT);

        // FETCH starved on t4: timeout pulse in the 4th wait cycle, then the count restarts.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, RT, 1'b0);
            chk("starve_wait", b_st, b_ctrl, 4'd0, F_WAIT);
        end
        drive(1'b1, RT, 1'b0);
        chk("starve_timeout", b_st, b_ctrl, 4'd0, F_TO);
        drive(1'b1, RT, 1'b0);
        chk("starve_after", b_st, b_ctrl, 4'd0, F_WAIT);

        // Reset in the middle of a MEMRD wait.
        do_reset();
        step2("mrst_fetch", RT, 1, 0, F_RDY);
        step2("mrst_dec",   LW, 1, 1, DEC);
        step2("mrst_adr",   LW, 1, 2, MEMADR);
        step2("mrst_wait",  LW, 0, 3, MEMRD);
        step2("mrst_wait",  LW, 0, 3, MEMRD);
        drive(1'b0, LW, 1'b0);
        chk("mrst_assert", b_st, b_ctrl, 4'd3, MEMRD);
        for (int k = 0; k < 3; k++) step2("mrst_after", RT, 0, 0, F_WAIT);
        drive(1'b1, RT, 1'b0);
        chk("mrst_cnt_cleared", b_st, b_ctrl, 4'd0, F_TO);
        chk("mrst_t16_wait", a_st, a_ctrl, 4'd0, F_WAIT);
        step2("mrst_j_fetch", RT, 1, 0, F_RDY);
        step2("mrst_j_dec",   J,  1, 1, DEC);
        step2("mrst_j_jump",  J,  1, 9, JUMP);
        step2("mrst_j_back",  RT, 0, 0, F_WAIT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
